// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_e;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

endpackage

// File: rtl/reg_file_mp_rd.sv
// One synchronous read port: range/zero-entry masking, optional write bypass,
// and an output register that holds its value when the port is not enabled.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH_P    = RF_WIDTH,
    parameter int DEPTH_P    = RF_DEPTH,
    parameter int ZERO_REG_P = 1,
    parameter int BYPASS_P   = 1,
    localparam int AW        = $clog2(DEPTH_P)
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [AW-1:0]      raddr,
    input  logic [WIDTH_P-1:0] mem_rdata,
    input  logic               wr_fire,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH_P-1:0] wdata,
    output logic [WIDTH_P-1:0] rdata
);

    logic               in_range;
    logic               is_zero;
    logic               hit;
    logic [WIDTH_P-1:0] rd_next;

    // A full power-of-two depth makes every address legal.
    generate
        if ((1 << AW) == DEPTH_P) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = {1'b0, raddr} < (AW+1)'(DEPTH_P);
        end
    endgenerate

    assign is_zero = (ZERO_REG_P != 0) && (raddr == '0);
    assign hit     = (BYPASS_P != 0) && wr_fire && (waddr == raddr);

    always_comb begin
        rd_next = mem_rdata;
        if (!in_range || is_zero) begin
            rd_next = '0;
        end else if (hit) begin
            rd_next = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= rd_next;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with a post-reset clearing
// sequencer; ready stays low until every entry has been zeroed.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int WIDTH_P    = RF_WIDTH,
    parameter int DEPTH_P    = RF_DEPTH,
    parameter int NUM_READ_P = 2,
    parameter int ZERO_REG_P = 1,
    parameter int BYPASS_P   = 1,
    localparam int AW        = $clog2(DEPTH_P)
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rv,
    input  logic [NUM_READ_P-1:0][AW-1:0]       raddr,
    output logic [NUM_READ_P-1:0][WIDTH_P-1:0]  rdata,
    input  logic                                wv,
    input  logic [AW-1:0]                       waddr,
    input  logic [WIDTH_P-1:0]                  wdata,
    output logic                                ready
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_P - 1);

    rf_state_e          state_q, state_d;
    logic [AW-1:0]      clr_ptr_q, clr_ptr_d;
    logic               run;
    logic               wr_in_range;
    logic               wr_fire;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [WIDTH_P-1:0] mem_wdata;
    logic [WIDTH_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // The clear walk zeroes one entry per cycle and hands over after the last one.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = RUN;
                    clr_ptr_d = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    assign run   = (state_q == RUN);
    assign ready = run;

    generate
        if ((1 << AW) == DEPTH_P) begin : g_wfull
            assign wr_in_range = 1'b1;
        end else begin : g_wpart
            assign wr_in_range = {1'b0, waddr} < (AW+1)'(DEPTH_P);
        end
    endgenerate

    assign wr_fire = run && wv && wr_in_range && !((ZERO_REG_P != 0) && (waddr == '0));

    assign mem_we    = (!run && !reset) || wr_fire;
    assign mem_waddr = run ? waddr : clr_ptr_q;
    assign mem_wdata = run ? wdata : '0;

    // Storage has no reset of its own so it can map onto a RAM-style array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        for (genvar i = 0; i < NUM_READ_P; i++) begin : g_rd
            rf_read_port #(
                .WIDTH_P    (WIDTH_P),
                .DEPTH_P    (DEPTH_P),
                .ZERO_REG_P (ZERO_REG_P),
                .BYPASS_P   (BYPASS_P)
            ) u_port (
                .clk       (clk),
                .reset     (reset),
                .en        (run && rv),
                .raddr     (raddr[i]),
                .mem_rdata (mem[raddr[i]]),
                .wr_fire   (wr_fire),
                .waddr     (waddr),
                .wdata     (wdata),
                .rdata     (rdata[i])
            );
        end
    endgenerate

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the core's 2-read/1-write register file. It generalises width, depth and read-port count, and adds a post-reset clearing sequencer so every entry reads 0 after reset. It also adds an optional hardwired-zero entry, optional write-to-read bypass, and read-data hold when a read is not enabled. It sits in the decode stage and feeds operand muxes; the writeback stage drives the write port.

Parameters:
WIDTH_P, 32, data bits per entry
DEPTH_P, 32, number of entries; any value >= 2, need not be a power of two
NUM_READ_P, 2, number of synchronous read ports (1..4)
ZERO_REG_P, 1, 1 = entry 0 reads 0 and ignores writes
BYPASS_P, 1, 1 = same-cycle write to a read address is forwarded (write-first); 0 = read returns old data
AW (localparam), $clog2(DEPTH_P), address width

Ports:
clk  in  1  sole clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
rv  in  1  read enable, common to all read ports
raddr  in  NUM_READ_P x AW  per-port read address, packed array
rdata  out  NUM_READ_P x WIDTH_P  per-port registered read data
wv  in  1  write enable
waddr  in  AW  write address
wdata  in  WIDTH_P  write data
ready  out  1  high when the array is initialised and accepting reads and writes

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- FSM states: CLEAR and RUN.
  - While reset is high: state=CLEAR, clr_ptr=0, all rdata=0, ready=0.
  - CLEAR, reset low: write 0 to mem[clr_ptr]; clr_ptr++ each cycle. On clr_ptr==DEPTH_P-1, go to RUN next cycle.
  - Clear takes exactly DEPTH_P cycles after reset deasserts. ready rises on the cycle after the last clear write.
  - RUN: ready=1. Stays in RUN until reset.
- Reset asserted mid-CLEAR or in RUN: return to CLEAR, clr_ptr=0, and restart the full clear. Partial contents are not trusted.
- Accesses during CLEAR:
  - wv is ignored.
  - rv is ignored; rdata holds 0.
  - No indication is given that an access was dropped; callers must gate on ready.
- Write (RUN): mem[waddr] <= wdata when wv=1. Suppressed when:
  - ZERO_REG_P=1 and waddr==0;
  - waddr >= DEPTH_P (out of range).
- Read (RUN), 1-cycle latency: if rv=1, for each port i, rdata[i] is set on the next edge to:
  - 0 if ZERO_REG_P=1 and raddr[i]==0;
  - 0 if raddr[i] >= DEPTH_P;
  - wdata if BYPASS_P=1, wv=1, waddr==raddr[i] and the write is not suppressed;
  - mem[raddr[i]] otherwise (pre-write value when BYPASS_P=0).
- rv=0: rdata holds its previous value (pipeline stall support).
- Multiple ports reading the same address all return the same value; there are no port conflicts.
- Simultaneous write and read of a suppressed address (x0): the read returns 0 and nothing is forwarded.
- Storage is never reset directly. Only the CLEAR sequencer zeroes it, so the array maps to a RAM-style flop array.

Decomposition:
- Package reg_file_pkg holds:
  - typedef rf_state_e {CLEAR, RUN};
  - the default constants RF_WIDTH=32 and RF_DEPTH=32.
- Sub-module rf_read_port: one instance per read port via generate. Contains the address-range check, zero-entry check, bypass mux and output hold register.
- The top level holds the storage array, the write logic and the clear FSM.

Test Plan:
1. Pulse reset for 1 cycle with defaults -> ready=0 for exactly 32 cycles after reset falls, then 1. Reading all 32 addresses yields 0.
2. RUN: write 0xDEADBEEF to entry 5, then next cycle raddr[0]=5 with rv=1 -> rdata[0]=0xDEADBEEF one cycle later.
3. Same cycle wv=1, waddr=7, wdata=0x1234 and raddr[1]=7 -> rdata[1]=0x1234 with BYPASS_P=1; with BYPASS_P=0, rdata[1] holds the old value 0.
4. Write 0xFFFFFFFF to address 0 with ZERO_REG_P=1, then read address 0 on both ports -> both rdata=0, including the same-cycle bypass case.
5. rdata[0]=0xA5A5A5A5 from a prior read; set rv=0 for 3 cycles while changing raddr and writing that entry -> rdata[0] stays 0xA5A5A5A5. With rv=1 it updates.
6. DEPTH_P=20: assert reset at clear cycle 10 for 1 cycle -> clear restarts and ready rises 20 cycles after the second reset. Write then read at address 25 -> the write is ignored and the read returns 0.
